// File: rtl/pu_riscv_ahb3_mmio_arb.sv
// pu_riscv_ahb3_mmio_arb: round-robin AHB3-Lite arbiter sharing one slave among MASTERS masters
// Ports: HCLK/HRESET (sync, active-high); mst_* flattened per-master buses (master i uses
// slice [i*W +: W]); slv_* the single shared slave. Optional HMASTLOCK support is compiled
// in with `define PU_RISCV_AHB3_ARB_HMASTLOCK_EN (adds mst_HMASTLOCK / slv_HMASTLOCK).
module pu_riscv_ahb3_mmio_arb #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int MASTERS    = 2
) (
    input  logic                           HCLK,
    input  logic                           HRESET,
    input  logic [2*MASTERS-1:0]           mst_HTRANS,
    input  logic [HADDR_SIZE*MASTERS-1:0]  mst_HADDR,
    input  logic [MASTERS-1:0]             mst_HWRITE,
    input  logic [3*MASTERS-1:0]           mst_HSIZE,
    input  logic [3*MASTERS-1:0]           mst_HBURST,
    input  logic [HDATA_SIZE*MASTERS-1:0]  mst_HWDATA,
`ifdef PU_RISCV_AHB3_ARB_HMASTLOCK_EN
    input  logic [MASTERS-1:0]             mst_HMASTLOCK,
    output logic                           slv_HMASTLOCK,
`endif
    output logic [HDATA_SIZE-1:0]          mst_HRDATA,
    output logic [MASTERS-1:0]             mst_HREADY,
    output logic [MASTERS-1:0]             mst_HRESP,
    output logic [1:0]                     slv_HTRANS,
    output logic [HADDR_SIZE-1:0]          slv_HADDR,
    output logic                           slv_HWRITE,
    output logic [2:0]                     slv_HSIZE,
    output logic [2:0]                     slv_HBURST,
    output logic [HDATA_SIZE-1:0]          slv_HWDATA,
    output logic                           slv_HREADY,
    input  logic [HDATA_SIZE-1:0]          slv_HRDATA,
    input  logic                           slv_HREADYOUT,
    input  logic                           slv_HRESP
);
    localparam int         IW     = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;
    localparam logic [2:0] INCR   = 3'd1;

    logic [IW-1:0]      gnt_q, gnt_d, dwn_q, rr_q, rr_d, nxt;
    logic [3:0]         beat_q, beat_d;
    logic               dvalid_q;
    logic [MASTERS-1:0] req;
    logic [1:0]         own_trans;
    logic [2:0]         own_burst;
    logic               own_lock, arb, hit;
    int                 idx;

    assign own_trans  = mst_HTRANS[2*gnt_q +: 2];
    assign own_burst  = mst_HBURST[3*gnt_q +: 3];
    assign slv_HTRANS = HRESET ? IDLE : own_trans;
    assign slv_HADDR  = mst_HADDR[HADDR_SIZE*gnt_q +: HADDR_SIZE];
    assign slv_HWRITE = mst_HWRITE[gnt_q];
    assign slv_HSIZE  = mst_HSIZE[3*gnt_q +: 3];
    assign slv_HBURST = own_burst;
    assign slv_HWDATA = mst_HWDATA[HDATA_SIZE*dwn_q +: HDATA_SIZE];
    assign slv_HREADY = slv_HREADYOUT;
    assign mst_HRDATA = slv_HRDATA;

`ifdef PU_RISCV_AHB3_ARB_HMASTLOCK_EN
    assign own_lock      = mst_HMASTLOCK[gnt_q];
    assign slv_HMASTLOCK = own_lock;
`else
    assign own_lock = 1'b0;
`endif

    always_comb begin
        req        = '0;
        mst_HREADY = '0;
        mst_HRESP  = '0;
        for (int i = 0; i < MASTERS; i++) begin
            req[i] = mst_HTRANS[2*i+1];
        end
        // Owner and data-phase master follow the slave; other requesters are stalled,
        // idle masters see a zero-wait OKAY.
        for (int i = 0; i < MASTERS; i++) begin
            mst_HREADY[i] = HRESET | ((IW'(i) == gnt_q || (IW'(i) == dwn_q && dvalid_q)) ? slv_HREADYOUT : !req[i]);
            mst_HRESP[i]  = !HRESET && dvalid_q && IW'(i) == dwn_q && slv_HRESP;
        end
    end

    always_comb begin
        beat_d = beat_q;
        if (slv_HREADYOUT)
            beat_d = own_trans == NONSEQ ? (own_burst[2:1] == 2'd0 ? 4'd0 :
                                            own_burst[2:1] == 2'd1 ? 4'd3 :
                                            own_burst[2:1] == 2'd2 ? 4'd7 : 4'd15) :
                     own_trans == SEQ    ? (beat_q == 4'd0 ? 4'd0 : beat_q - 4'd1) :
                     own_trans == IDLE   ? 4'd0 : beat_q;
    end

    // An undefined-length INCR has no known end, so the owner keeps the bus for as long
    // as it drives an INCR transfer; IDLE or a NONSEQ of another burst type releases it.
    assign arb = slv_HREADYOUT && beat_d == 4'd0 && own_trans != BUSY &&
                 !(own_burst == INCR && own_trans != IDLE) && !own_lock;

    // Search other requesters from rr+1 upward; the owner keeps the bus only when
    // nobody else requests, so back-to-back singles alternate between masters.
    always_comb begin
        nxt = gnt_q;
        hit = 1'b0;
        idx = 0;
        for (int k = 1; k <= MASTERS; k++) begin
            idx = (int'(rr_q) + k) % MASTERS;
            if (!hit && req[idx] && IW'(idx) != gnt_q) begin
                nxt = IW'(idx);
                hit = 1'b1;
            end
        end
        gnt_d = (arb && hit) ? nxt : gnt_q;
        rr_d  = (arb && hit) ? gnt_q : rr_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            gnt_q    <= '0;
            dwn_q    <= '0;
            rr_q     <= IW'(MASTERS - 1);
            beat_q   <= '0;
            dvalid_q <= 1'b0;
        end else if (slv_HREADYOUT) begin
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            dwn_q    <= gnt_q;
            beat_q   <= beat_d;
            dvalid_q <= own_trans[1];
        end
    end
endmodule

// File: tb/tb_pu_riscv_ahb3_mmio_arb.sv
// tb_pu_riscv_ahb3_mmio_arb: table-driven bench with write/read-data scoreboard
module tb_pu_riscv_ahb3_mmio_arb;
    localparam logic [1:0]  ID = 2'd0, NS = 2'd2, SQ = 2'd3;
    localparam logic [2:0]  SG = 3'd0, I4 = 3'd3, W8 = 3'd4;
    localparam logic [31:0] A0 = 32'h8000_1080, A1 = 32'h8000_1000, Z = 32'h0;
    localparam logic        Y = 1'b1, N = 1'b0;

    typedef struct {
        logic rst;
        logic [1:0] t0; logic [2:0] b0; logic [31:0] a0; logic w0;
        logic [1:0] t1; logic [2:0] b1; logic [31:0] a1; logic w1;
        logic rdy, resp;
        logic [1:0] e_tr; logic [31:0] e_ad; logic own; logic [1:0] e_rd, e_rs;
    } vec_t;
    typedef struct { logic wr; logic [31:0] d; } sb_t;

    logic        HCLK = 1'b0, HRESET = 1'b1;
    logic [3:0]  mst_HTRANS = '0;
    logic [63:0] mst_HADDR = '0;
    logic [1:0]  mst_HWRITE = '0;
    logic [5:0]  mst_HSIZE = {3'd2, 3'd2};
    logic [5:0]  mst_HBURST = '0;
    logic [63:0] mst_HWDATA = {32'h1, 32'h41};
    logic [31:0] mst_HRDATA, slv_HADDR, slv_HWDATA;
    logic [31:0] slv_HRDATA = 32'hDEAD_BEEF;
    logic [1:0]  mst_HREADY, mst_HRESP, slv_HTRANS;
    logic [2:0]  slv_HSIZE, slv_HBURST;
    logic        slv_HWRITE, slv_HREADY;
    logic        slv_HREADYOUT = 1'b1, slv_HRESP = 1'b0;
`ifdef PU_RISCV_AHB3_ARB_HMASTLOCK_EN
    logic [1:0]  mst_HMASTLOCK = '0;
    logic        slv_HMASTLOCK;
`endif

    int   checks = 0, failures = 0;
    sb_t  q[$];
    vec_t tv[29];

    pu_riscv_ahb3_mmio_arb #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MASTERS(2)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .mst_HTRANS(mst_HTRANS), .mst_HADDR(mst_HADDR), .mst_HWRITE(mst_HWRITE),
        .mst_HSIZE(mst_HSIZE), .mst_HBURST(mst_HBURST), .mst_HWDATA(mst_HWDATA),
`ifdef PU_RISCV_AHB3_ARB_HMASTLOCK_EN
        .mst_HMASTLOCK(mst_HMASTLOCK), .slv_HMASTLOCK(slv_HMASTLOCK),
`endif
        .mst_HRDATA(mst_HRDATA), .mst_HREADY(mst_HREADY), .mst_HRESP(mst_HRESP),
        .slv_HTRANS(slv_HTRANS), .slv_HADDR(slv_HADDR), .slv_HWRITE(slv_HWRITE),
        .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST), .slv_HWDATA(slv_HWDATA),
        .slv_HREADY(slv_HREADY), .slv_HRDATA(slv_HRDATA),
        .slv_HREADYOUT(slv_HREADYOUT), .slv_HRESP(slv_HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge HCLK);
        HRESET        = v.rst;
        mst_HTRANS    = {v.t1, v.t0};
        mst_HBURST    = {v.b1, v.b0};
        mst_HADDR     = {v.a1, v.a0};
        mst_HWRITE    = {v.w1, v.w0};
        slv_HREADYOUT = v.rdy;
        slv_HRESP     = v.resp;
        #1;
        chk("slv_htrans", 32'(slv_HTRANS), 32'(v.e_tr));
        if (v.e_tr != ID) chk("slv_haddr", slv_HADDR, v.e_ad);
        chk("mst_hready", 32'(mst_HREADY), 32'(v.e_rd));
        chk("mst_hresp", 32'(mst_HRESP), 32'(v.e_rs));
        chk("slv_hready", 32'(slv_HREADY), 32'(v.rdy));
        if (v.rst) q.delete();
        else begin
            if (q.size() > 0) begin
                if (q[0].wr) chk("slv_hwdata", slv_HWDATA, q[0].d);
                else if (v.rdy) chk("mst_hrdata", mst_HRDATA, q[0].d);
                if (v.rdy) void'(q.pop_front());
            end
            if (v.e_tr[1] && v.rdy) begin
                sb_t s;
                s.wr = v.own ? v.w1 : v.w0;
                s.d  = !s.wr ? 32'hDEAD_BEEF : v.own ? 32'h1 : 32'h41;
                q.push_back(s);
            end
        end
    endtask

    initial begin
        tv = '{
            '{Y,NS,SG,A0,Y,NS,SG,A1,Y,Y,N,ID,Z,N,2'b11,2'b00},
            '{Y,NS,SG,A0,Y,NS,SG,A1,Y,Y,N,ID,Z,N,2'b11,2'b00},
            '{Y,NS,SG,A0,Y,NS,SG,A1,Y,Y,N,ID,Z,N,2'b11,2'b00},
            '{N,NS,SG,A0,Y,NS,SG,A1,Y,Y,N,NS,A0,N,2'b01,2'b00},
            '{N,NS,SG,A0,Y,NS,SG,A1,Y,Y,N,NS,A1,Y,2'b11,2'b00},
            '{N,NS,SG,A0,Y,NS,SG,A1,Y,Y,N,NS,A0,N,2'b11,2'b00},
            '{N,NS,SG,A0,Y,NS,SG,A1,Y,Y,N,NS,A1,Y,2'b11,2'b00},
            '{N,NS,I4,32'h100,Y,NS,SG,A1,Y,Y,N,NS,32'h100,N,2'b11,2'b00},
            '{N,SQ,I4,32'h104,Y,NS,SG,A1,Y,Y,N,SQ,32'h104,N,2'b01,2'b00},
            '{N,SQ,I4,32'h108,Y,NS,SG,A1,Y,Y,N,SQ,32'h108,N,2'b01,2'b00},
            '{N,SQ,I4,32'h10C,Y,NS,SG,A1,Y,Y,N,SQ,32'h10C,N,2'b01,2'b00},
            '{N,ID,SG,Z,Y,NS,SG,A1,N,Y,N,NS,A1,Y,2'b11,2'b00},
            '{N,NS,SG,A0,Y,ID,SG,A1,N,N,N,ID,Z,Y,2'b00,2'b00},
            '{N,NS,SG,A0,Y,ID,SG,A1,N,N,N,ID,Z,Y,2'b00,2'b00},
            '{N,NS,SG,A0,Y,ID,SG,A1,N,Y,N,ID,Z,Y,2'b10,2'b00},
            '{N,NS,SG,A0,Y,ID,SG,A1,N,Y,N,NS,A0,N,2'b11,2'b00},
            '{N,NS,W8,32'h200,Y,NS,SG,A1,Y,Y,N,NS,32'h200,N,2'b01,2'b00},
            '{N,SQ,W8,32'h204,Y,NS,SG,A1,Y,Y,N,SQ,32'h204,N,2'b01,2'b00},
            '{N,SQ,W8,32'h208,Y,NS,SG,A1,Y,N,Y,SQ,32'h208,N,2'b00,2'b01},
            '{N,ID,W8,32'h208,Y,NS,SG,A1,Y,Y,Y,ID,Z,N,2'b01,2'b01},
            '{N,ID,SG,Z,Y,NS,SG,A1,Y,Y,N,NS,A1,Y,2'b11,2'b00},
            '{N,ID,SG,Z,Y,ID,SG,A1,Y,Y,N,ID,Z,Y,2'b11,2'b00},
            '{N,NS,I4,32'h300,Y,ID,SG,A1,Y,Y,N,ID,Z,Y,2'b10,2'b00},
            '{N,NS,I4,32'h300,Y,ID,SG,A1,Y,Y,N,NS,32'h300,N,2'b11,2'b00},
            '{N,SQ,I4,32'h304,Y,NS,SG,A1,Y,Y,N,SQ,32'h304,N,2'b01,2'b00},
            '{Y,SQ,I4,32'h308,Y,NS,SG,A1,Y,Y,N,ID,Z,N,2'b11,2'b00},
            '{N,NS,SG,32'h400,Y,NS,SG,A1,Y,Y,N,NS,32'h400,N,2'b01,2'b00},
            '{N,ID,SG,Z,Y,NS,SG,A1,Y,Y,N,NS,A1,Y,2'b11,2'b00},
            '{N,ID,SG,Z,Y,ID,SG,A1,Y,Y,N,ID,Z,Y,2'b11,2'b00}
        };
        foreach (tv[i]) apply(tv[i]);
        // Parking: m0 alone keeps the bus across consecutive singles once it wins it.
        for (int k = 0; k < 4; k++)
            apply('{N,NS,SG,32'h500,Y,ID,SG,A1,Y,Y,N,(k == 0) ? ID : NS,32'h500,N,(k == 0) ? 2'b10 : 2'b11,2'b00});
        apply('{N,ID,SG,Z,Y,ID,SG,A1,Y,Y,N,ID,Z,N,2'b11,2'b00});
`ifdef PU_RISCV_AHB3_ARB_HMASTLOCK_EN
        // Locked read then write from m0 must both complete before m1 gets the bus.
        apply('{Y,ID,SG,Z,Y,ID,SG,A1,Y,Y,N,ID,Z,N,2'b11,2'b00});
        mst_HMASTLOCK = 2'b01;
        apply('{N,NS,SG,32'h600,N,NS,SG,A1,Y,Y,N,NS,32'h600,N,2'b01,2'b00});
        apply('{N,NS,SG,32'h604,Y,NS,SG,A1,Y,Y,N,NS,32'h604,N,2'b01,2'b00});
        mst_HMASTLOCK = 2'b00;
        apply('{N,ID,SG,Z,Y,NS,SG,A1,Y,Y,N,ID,Z,N,2'b01,2'b00});
        apply('{N,ID,SG,Z,Y,NS,SG,A1,Y,Y,N,NS,A1,Y,2'b11,2'b00});
        apply('{N,ID,SG,Z,Y,ID,SG,A1,Y,Y,N,ID,Z,Y,2'b11,2'b00});
`endif
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
